// File: rtl/stream_demux4.sv
// 1-to-4 stream demultiplexer: one tagged valid/ready input routed into four
// single-entry output slots, each with an independent valid/ready handshake.
module stream_demux4 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]   xfer_count
);

  // state | meaning
  // EMPTY | slot holds no word, out_valid low
  // FULL  | slot holds a word awaiting its consumer
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t      state_q [4];
  slot_state_t      state_d [4];
  logic [WIDTH-1:0] slot_q  [4];
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             accept;

  // A full slot can take a new word in the same cycle its consumer drains it.
  assign in_ready = (state_q[in_sel] == EMPTY) | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) load[in_sel] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      if (load[k])       state_d[k] = FULL;
      else if (drain[k]) state_d[k] = EMPTY;
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    for (int k = 0; k < 4; k++) out_valid[k] = (state_q[k] == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) state_q[k] <= EMPTY;
    end else begin
      for (int k = 0; k < 4; k++) state_q[k] <= state_d[k];
    end
  end

  // Slot data only changes on a load, so a stalled word stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) slot_q[k] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      xfer_count <= '0;
    else if (accept) xfer_count <= xfer_count + 1'b1;
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH] = slot_q[g];
  end

endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4: table of per-cycle vectors plus hand
// sequences for mid-stream reset and counter wrap on a narrow-counter instance.
module tb_stream_demux4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [15:0] xfer_count;

  logic        n_in_ready;
  logic [3:0]  n_out_valid;
  logic [31:0] n_out_data;
  logic [3:0]  n_xfer_count;

  int n_checks;
  int n_fail;

  stream_demux4 #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .xfer_count(xfer_count)
  );

  stream_demux4 #(.WIDTH(8), .CNT_W(4)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_data(n_out_data), .xfer_count(n_xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  dat;
    logic [3:0]  ordy;
    logic        ex_rdy;
    logic [3:0]  ex_vld;
    logic [31:0] ex_dat;
    logic [15:0] ex_cnt;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            vld   sel   dat    ordy     rdy   vld      data          cnt
    vecs[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 32'h00A50000, 16'd1};
    vecs[1]  = '{1'b1, 2'd2, 8'h3C, 4'b0000, 1'b0, 4'b0100, 32'h00A50000, 16'd1};
    vecs[2]  = '{1'b1, 2'd1, 8'h11, 4'b0000, 1'b1, 4'b0110, 32'h00A51100, 16'd2};
    vecs[3]  = '{1'b1, 2'd2, 8'h3C, 4'b0100, 1'b1, 4'b0110, 32'h003C1100, 16'd3};
    vecs[4]  = '{1'b0, 2'd0, 8'h00, 4'b0110, 1'b1, 4'b0000, 32'h003C1100, 16'd3};
    vecs[5]  = '{1'b1, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0001, 32'h003C1100, 16'd4};
    vecs[6]  = '{1'b1, 2'd1, 8'h01, 4'b1111, 1'b1, 4'b0010, 32'h003C0100, 16'd5};
    vecs[7]  = '{1'b1, 2'd2, 8'h02, 4'b1111, 1'b1, 4'b0100, 32'h00020100, 16'd6};
    vecs[8]  = '{1'b1, 2'd3, 8'h03, 4'b1111, 1'b1, 4'b1000, 32'h03020100, 16'd7};
    vecs[9]  = '{1'b1, 2'd0, 8'h04, 4'b1111, 1'b1, 4'b0001, 32'h03020104, 16'd8};
    vecs[10] = '{1'b1, 2'd1, 8'h05, 4'b1111, 1'b1, 4'b0010, 32'h03020504, 16'd9};
    vecs[11] = '{1'b1, 2'd2, 8'h06, 4'b1111, 1'b1, 4'b0100, 32'h03060504, 16'd10};
    vecs[12] = '{1'b1, 2'd3, 8'h07, 4'b1111, 1'b1, 4'b1000, 32'h07060504, 16'd11};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h07060504, 16'd11};
    vecs[14] = '{1'b1, 2'd3, 8'h5A, 4'b0000, 1'b1, 4'b1000, 32'h5A060504, 16'd12};
    vecs[15] = '{1'b0, 2'd3, 8'h77, 4'b0000, 1'b0, 4'b1000, 32'h5A060504, 16'd12};
    vecs[16] = '{1'b1, 2'd3, 8'h77, 4'b0111, 1'b0, 4'b1000, 32'h5A060504, 16'd12};
    vecs[17] = '{1'b1, 2'd0, 8'h99, 4'b0000, 1'b1, 4'b1001, 32'h5A060599, 16'd13};
    vecs[18] = '{1'b1, 2'd3, 8'h77, 4'b1001, 1'b1, 4'b1000, 32'h77060599, 16'd14};
    vecs[19] = '{1'b0, 2'd0, 8'h00, 4'b1000, 1'b1, 4'b0000, 32'h77060599, 16'd14};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    out_ready = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_valid", {28'd0, out_valid}, 32'h0);
    chk("reset_data", out_data, 32'h0);
    chk("reset_count", {16'd0, xfer_count}, 32'd0);

    // Load slots 0 and 2, then reset asynchronously mid-stream.
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h42;
    @(posedge clk); #1;
    chk("pre_rst_valid0", {28'd0, out_valid}, 32'h1);
    @(negedge clk);
    in_sel = 2'd2; in_data = 8'h24;
    @(posedge clk); #1;
    chk("pre_rst_valid02", {28'd0, out_valid}, 32'h5);
    chk("pre_rst_data", out_data, 32'h00240042);
    chk("pre_rst_count", {16'd0, xfer_count}, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {28'd0, out_valid}, 32'h0);
    chk("async_rst_data", out_data, 32'h0);
    chk("async_rst_count", {16'd0, xfer_count}, 32'd0);
    chk("async_rst_count_n", {28'd0, n_xfer_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("post_rst_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
    end

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].vld;
      in_sel    = vecs[i].sel;
      in_data   = vecs[i].dat;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].ex_rdy});
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), {28'd0, out_valid}, {28'd0, vecs[i].ex_vld});
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].ex_dat);
      chk($sformatf("v%0d_count", i), {16'd0, xfer_count}, {16'd0, vecs[i].ex_cnt});
      chk($sformatf("v%0d_count_n", i), {28'd0, n_xfer_count}, {28'd0, vecs[i].ex_cnt[3:0]});
    end

    // Three more accepts bring the total to 17; the 4-bit counter wraps to 1.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sel    = 2'(j);
      in_data   = 8'hE0 + 8'(j);
      out_ready = 4'b1111;
      #1;
      chk($sformatf("wrap%0d_in_ready", j), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("wrap_count_narrow", {28'd0, n_xfer_count}, 32'd1);
    chk("wrap_count_wide", {16'd0, xfer_count}, 32'd17);
    chk("wrap_last_data", {24'd0, out_data[23:16]}, 32'hE2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
